// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for the board RGB LED. Duty codes arrive over a
// valid/ready load port and are swapped in only at a PWM period boundary.
module rgb_pwm_driver #(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 390
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] duty_r,
    input  logic [CNT_W-1:0] duty_g,
    input  logic [CNT_W-1:0] duty_b,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             period_start,
    output logic             R,
    output logic             G,
    output logic             B
);

    localparam int PRE_W = 16;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    logic [PRE_W-1:0] prescaler;
    logic [CNT_W-1:0] pwm_cnt;
    logic             tick;
    logic             wrap;

    logic [CNT_W-1:0] active_r, active_g, active_b;
    logic [CNT_W-1:0] pending_r, pending_g, pending_b;
    logic             pending;

    // Unsigned full-width compare: duty 0 is always off, max duty is never 100%.
    function automatic logic channel_on(input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W-1:0] duty);
        return cnt < duty;
    endfunction

    assign tick       = (prescaler == PRE_LAST);
    assign wrap       = tick && (pwm_cnt == CNT_LAST);
    assign load_ready = !pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Apply has priority: a pending set can only be replaced after it is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            pending_r <= '0;
            pending_g <= '0;
            pending_b <= '0;
            active_r  <= '0;
            active_g  <= '0;
            active_b  <= '0;
        end else if (wrap && pending) begin
            active_r <= pending_r;
            active_g <= pending_g;
            active_b <= pending_b;
            pending  <= 1'b0;
        end else if (load_valid && !pending) begin
            pending_r <= duty_r;
            pending_g <= duty_g;
            pending_b <= duty_b;
            pending   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            R            <= 1'b0;
            G            <= 1'b0;
            B            <= 1'b0;
            period_start <= 1'b0;
        end else begin
            R            <= channel_on(pwm_cnt, active_r);
            G            <= channel_on(pwm_cnt, active_g);
            B            <= channel_on(pwm_cnt, active_b);
            period_start <= wrap;
        end
    end

endmodule
